// File: rtl/axi_txn_regulator.sv
// Outstanding-transaction regulator for an AXI address path, with flush/quiesce sequencing.
// Optional stall statistics counter enabled by defining AXI_TXN_REGULATOR_STATS_EN.
module axi_txn_regulator #(
  parameter int unsigned MAX_WR_TXN = 8,
  parameter int unsigned MAX_RD_TXN = 8
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  input  logic        aw_valid_i,
  output logic        aw_ready_o,
  output logic        aw_valid_o,
  input  logic        aw_ready_i,
  input  logic        ar_valid_i,
  output logic        ar_ready_o,
  output logic        ar_valid_o,
  input  logic        ar_ready_i,
  input  logic        b_valid_i,
  input  logic        b_ready_i,
  input  logic        r_valid_i,
  input  logic        r_ready_i,
  input  logic        r_last_i,
  input  logic        flush_req_i,
  output logic        flush_ack_o,
  output logic [7:0]  wr_cnt_o,
  output logic [7:0]  rd_cnt_o,
  output logic        err_o
`ifdef AXI_TXN_REGULATOR_STATS_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  // state | meaning
  // RUN   | new address handshakes admitted while below the outstanding limits
  // DRAIN | flush requested; only already-presented handshakes finish, responses retire
  // HALT  | quiesced: nothing outstanding, flush_ack_o high
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [7:0] MAX_WR = 8'(MAX_WR_TXN);
  localparam logic [7:0] MAX_RD = 8'(MAX_RD_TXN);

  state_e     state_q, state_d;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic       aw_pend_q, aw_pend_d;
  logic       ar_pend_q, ar_pend_d;
  logic       err_q, err_d;
  logic       flush_ack_q, flush_ack_d;

  logic       aw_en, ar_en;
  logic       aw_hs, ar_hs, b_hs, r_hs;
  logic       drained;
  logic [8:0] wr_step, rd_step;

  // Returns {error, next_count}; coinciding inc/dec leaves the count alone.
  function automatic logic [8:0] cnt_next(input logic [7:0] cnt, input logic inc,
                                          input logic dec);
    logic [8:0] res;
    res = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == 8'hff) res[8] = 1'b1;
      else              res    = {1'b0, cnt + 8'd1};
    end else if (dec && !inc) begin
      if (cnt == 8'h00) res[8] = 1'b1;
      else              res    = {1'b0, cnt - 8'd1};
    end
    return res;
  endfunction

  // Enables depend on registered state only, so gating adds no combinational loop.
  assign aw_en = aw_pend_q | ((state_q == RUN) & (wr_cnt_q < MAX_WR));
  assign ar_en = ar_pend_q | ((state_q == RUN) & (rd_cnt_q < MAX_RD));

  assign aw_valid_o = aw_valid_i & aw_en;
  assign aw_ready_o = aw_ready_i & aw_en;
  assign ar_valid_o = ar_valid_i & ar_en;
  assign ar_ready_o = ar_ready_i & ar_en;

  assign aw_hs = aw_valid_o & aw_ready_i;
  assign ar_hs = ar_valid_o & ar_ready_i;
  assign b_hs  = b_valid_i & b_ready_i;
  assign r_hs  = r_valid_i & r_ready_i & r_last_i;

  assign drained = (wr_cnt_q == 8'd0) & (rd_cnt_q == 8'd0) & !aw_pend_q & !ar_pend_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!flush_req_i)  state_d = RUN;
        else if (drained)  state_d = HALT;
      end
      HALT:    if (!flush_req_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    wr_step     = cnt_next(wr_cnt_q, aw_hs, b_hs);
    rd_step     = cnt_next(rd_cnt_q, ar_hs, r_hs);
    wr_cnt_d    = wr_step[7:0];
    rd_cnt_d    = rd_step[7:0];
    err_d       = err_q | wr_step[8] | rd_step[8];
    // A presented-but-unaccepted request keeps its enable until the handshake.
    aw_pend_d   = aw_valid_o & !aw_ready_i;
    ar_pend_d   = ar_valid_o & !ar_ready_i;
    flush_ack_d = (state_d == HALT);
  end

`ifdef AXI_TXN_REGULATOR_STATS_EN
  logic        stall;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall = (aw_valid_i & !aw_en) | (ar_valid_i & !ar_en);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hffff_ffff)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!arst_ni) stall_cnt_q <= 32'd0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      state_q     <= RUN;
      wr_cnt_q    <= 8'd0;
      rd_cnt_q    <= 8'd0;
      aw_pend_q   <= 1'b0;
      ar_pend_q   <= 1'b0;
      err_q       <= 1'b0;
      flush_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      aw_pend_q   <= aw_pend_d;
      ar_pend_q   <= ar_pend_d;
      err_q       <= err_d;
      flush_ack_q <= flush_ack_d;
    end
  end

  assign flush_ack_o = flush_ack_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign rd_cnt_o    = rd_cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_axi_txn_regulator.sv
// Directed bench for axi_txn_regulator (MAX_WR_TXN=2, MAX_RD_TXN=4): vector table plus
// hand sequences for flush/drain, limit stalls and mid-run reset.
module tb_axi_txn_regulator;

  logic       clk_i = 1'b0;
  logic       arst_ni = 1'b0;
  logic       aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
  logic       ar_valid_i, ar_ready_o, ar_valid_o, ar_ready_i;
  logic       b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
  logic       flush_req_i, flush_ack_o, err_o;
  logic [7:0] wr_cnt_o, rd_cnt_o;
`ifdef AXI_TXN_REGULATOR_STATS_EN
  logic [31:0] stall_cnt_o;
`endif

  axi_txn_regulator #(.MAX_WR_TXN(2), .MAX_RD_TXN(4)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
    .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
    .wr_cnt_o(wr_cnt_o), .rd_cnt_o(rd_cnt_o), .err_o(err_o)
`ifdef AXI_TXN_REGULATOR_STATS_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Input bits: {flush, awv, awr, arv, arr, bv, br, rv, rr, rlast}
  localparam logic [9:0] IDLE = 10'h000;
  localparam logic [9:0] FL   = 10'h200;
  localparam logic [9:0] AWH  = 10'h180;
  localparam logic [9:0] AWV  = 10'h100;
  localparam logic [9:0] ARH  = 10'h060;
  localparam logic [9:0] ARV  = 10'h040;
  localparam logic [9:0] BH   = 10'h018;
  localparam logic [9:0] RL   = 10'h007;
  localparam logic [9:0] RN   = 10'h006;

  typedef struct {
    string      name;
    logic [9:0] in;
    logic [3:0] comb;   // {aw_valid_o, aw_ready_o, ar_valid_o, ar_ready_o} before the edge
    logic [7:0] wr;
    logic [7:0] rd;
    logic       err;
    logic       ack;
  } vec_t;

  vec_t tbl [18];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(input string n, input logic [9:0] in, input logic [3:0] c,
                              input logic [7:0] wr, input logic [7:0] rd,
                              input logic e, input logic a);
    vec_t v;
    v.name = n; v.in = in; v.comb = c; v.wr = wr; v.rd = rd; v.err = e; v.ack = a;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] v);
    {flush_req_i, aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i,
     b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i} = v;
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_comb(input string name, input logic [3:0] exp);
    #1;
    chk(name, {28'd0, aw_valid_o, aw_ready_o, ar_valid_o, ar_ready_o}, {28'd0, exp});
  endtask

  task automatic chk_regs(input string name, input logic [7:0] wr, input logic [7:0] rd,
                          input logic e, input logic a);
    chk({name, "/wr_cnt"}, wr_cnt_o, wr);
    chk({name, "/rd_cnt"}, rd_cnt_o, rd);
    chk({name, "/err"}, err_o, e);
    chk({name, "/flush_ack"}, flush_ack_o, a);
  endtask

  task automatic do_reset(input string name);
    arst_ni = 1'b0;
    drive(IDLE);
    step;
    step;
    arst_ni = 1'b1;
    chk_regs(name, 8'd0, 8'd0, 1'b0, 1'b0);
`ifdef AXI_TXN_REGULATOR_STATS_EN
    chk({name, "/stall_cnt"}, stall_cnt_o, 32'd0);
`endif
  endtask

  initial begin
    tbl[0]  = mk("aw1",           AWH,      4'b1100, 8'd1, 8'd0, 1'b0, 1'b0);
    tbl[1]  = mk("aw2",           AWH,      4'b1100, 8'd2, 8'd0, 1'b0, 1'b0);
    tbl[2]  = mk("aw3_held",      AWH,      4'b0000, 8'd2, 8'd0, 1'b0, 1'b0);
    tbl[3]  = mk("aw3_with_b",    AWH | BH, 4'b0000, 8'd1, 8'd0, 1'b0, 1'b0);
    tbl[4]  = mk("aw3_accepted",  AWH,      4'b1100, 8'd2, 8'd0, 1'b0, 1'b0);
    tbl[5]  = mk("ar1",           ARH,      4'b0011, 8'd2, 8'd1, 1'b0, 1'b0);
    tbl[6]  = mk("ar2",           ARH,      4'b0011, 8'd2, 8'd2, 1'b0, 1'b0);
    tbl[7]  = mk("ar3",           ARH,      4'b0011, 8'd2, 8'd3, 1'b0, 1'b0);
    tbl[8]  = mk("ar_and_rlast",  ARH | RL, 4'b0011, 8'd2, 8'd3, 1'b0, 1'b0);
    tbl[9]  = mk("r_nonlast",     RN,       4'b0000, 8'd2, 8'd3, 1'b0, 1'b0);
    tbl[10] = mk("r_last",        RL,       4'b0000, 8'd2, 8'd2, 1'b0, 1'b0);
    tbl[11] = mk("ar_wait",       ARV,      4'b0010, 8'd2, 8'd2, 1'b0, 1'b0);
    tbl[12] = mk("ar_accept",     ARH,      4'b0011, 8'd2, 8'd3, 1'b0, 1'b0);
    tbl[13] = mk("b_and_r_1",     BH | RL,  4'b0000, 8'd1, 8'd2, 1'b0, 1'b0);
    tbl[14] = mk("b_and_r_2",     BH | RL,  4'b0000, 8'd0, 8'd1, 1'b0, 1'b0);
    tbl[15] = mk("r_to_zero",     RL,       4'b0000, 8'd0, 8'd0, 1'b0, 1'b0);
    tbl[16] = mk("b_underflow",   BH,       4'b0000, 8'd0, 8'd0, 1'b1, 1'b0);
    tbl[17] = mk("err_sticky",    IDLE,     4'b0000, 8'd0, 8'd0, 1'b1, 1'b0);

    do_reset("reset0");

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].in);
      chk_comb({tbl[i].name, "/gate"}, tbl[i].comb);
      step;
      chk_regs(tbl[i].name, tbl[i].wr, tbl[i].rd, tbl[i].err, tbl[i].ack);
    end

    // Pending AW survives a flush, then drain to HALT and back to RUN.
    do_reset("reset1");
    drive(AWV);        chk_comb("pend_start", 4'b1000);      step;
    drive(AWV | FL);   chk_comb("pend_flush_rise", 4'b1000); step;
    drive(AWV | FL);   chk_comb("pend_in_drain", 4'b1000);   step;
    drive(AWH | FL);   chk_comb("pend_hs_drain", 4'b1100);   step;
    chk_regs("pend_hs_drain", 8'd1, 8'd0, 1'b0, 1'b0);
    drive(AWH | FL);   chk_comb("drain_blocks_aw", 4'b0000); step;
    chk_regs("drain_blocks_aw", 8'd1, 8'd0, 1'b0, 1'b0);
    drive(BH | FL);    step;
    chk_regs("drain_last_b", 8'd0, 8'd0, 1'b0, 1'b0);
    drive(FL);         step;
    chk_regs("halt_entry", 8'd0, 8'd0, 1'b0, 1'b1);
    drive(FL);         chk_comb("halt_idle", 4'b0000);       step;
    chk_regs("halt_hold", 8'd0, 8'd0, 1'b0, 1'b1);
    drive(AWH | FL);   chk_comb("halt_blocks_aw", 4'b0000);  step;
    drive(IDLE);       step;
    chk_regs("halt_exit", 8'd0, 8'd0, 1'b0, 1'b0);
    drive(AWH);        chk_comb("run_again", 4'b1100);       step;
    chk_regs("run_again", 8'd1, 8'd0, 1'b0, 1'b0);

    // Handshake on the flush rising cycle, then flush dropped mid-drain.
    do_reset("reset2");
    drive(ARH | FL);   chk_comb("hs_on_flush_rise", 4'b0011); step;
    chk_regs("hs_on_flush_rise", 8'd0, 8'd1, 1'b0, 1'b0);
    drive(ARH | FL);   chk_comb("drain_blocks_ar", 4'b0000);  step;
    chk_regs("drain_blocks_ar", 8'd0, 8'd1, 1'b0, 1'b0);
    drive(ARH);        chk_comb("flush_drop_cycle", 4'b0000); step;
    chk_regs("flush_drop", 8'd0, 8'd1, 1'b0, 1'b0);
    drive(ARH);        chk_comb("ar_after_drop", 4'b0011);    step;
    chk_regs("ar_after_drop", 8'd0, 8'd2, 1'b0, 1'b0);

    // Read limit stall, sticky error, then reset in the middle of traffic.
    do_reset("reset3");
    for (int i = 0; i < 4; i++) begin
      drive(ARH);
      step;
    end
    chk_regs("rd_at_limit", 8'd0, 8'd4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(ARV);
      chk_comb("ar_limit_blocked", 4'b0000);
      step;
    end
`ifdef AXI_TXN_REGULATOR_STATS_EN
    chk("stall_cnt_5", stall_cnt_o, 32'd5);
`endif
    drive(BH);  step;
    chk_regs("err_at_limit", 8'd0, 8'd4, 1'b1, 1'b0);
    drive(AWV); step;
    arst_ni = 1'b0;
    drive(AWV | ARV);
    step;
    arst_ni = 1'b1;
    drive(IDLE);
    chk_regs("midrun_reset", 8'd0, 8'd0, 1'b0, 1'b0);
`ifdef AXI_TXN_REGULATOR_STATS_EN
    chk("midrun_reset/stall_cnt", stall_cnt_o, 32'd0);
`endif
    drive(AWH); chk_comb("post_reset_aw", 4'b1100); step;
    chk_regs("post_reset_aw", 8'd1, 8'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
